// File: rtl/branch_predictor_table_pkg.sv
// sail_bp_pkg: definitions shared by the branch predictor table and its
// counter-update sub-module.
//   STATE_INIT / STATE_READY : table initialisation FSM encoding
//   sat_update()             : saturating up/down counter step (up to 4 bits)
//   weak_t()                 : weakly-taken initial counter value (MSB set)
package sail_bp_pkg;

  localparam logic [0:0] STATE_INIT  = 1'b0;
  localparam logic [0:0] STATE_READY = 1'b1;

  // Counters are carried in 4 bits (the widest legal CTR_W); callers
  // truncate the result back to their own width.
  function automatic logic [3:0] sat_update(input logic [3:0] ctr,
                                            input logic       taken,
                                            input int         ctr_w);
    logic [3:0] max_v;
    max_v = 4'((1 << ctr_w) - 1);
    if (taken) sat_update = (ctr >= max_v) ? max_v : ctr + 4'd1;
    else       sat_update = (ctr == 4'd0)  ? 4'd0  : ctr - 4'd1;
  endfunction

  // 1 followed by (ctr_w-1) zeros.
  function automatic logic [3:0] weak_t(input int ctr_w);
    weak_t = 4'(1 << (ctr_w - 1));
  endfunction

endpackage

// File: rtl/branch_predictor_table_sat.sv
// bp_sat_counter_update: combinational saturating next-value for one
// prediction counter. The top feeds it the entry addressed by the pending
// update; its output is both the table write data and the forwarded value.
//   ctr      : current counter value
//   taken    : resolved outcome (1 = count up, 0 = count down)
//   ctr_next : saturated result, never wraps
module bp_sat_counter_update
  import sail_bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next
);

  always_comb begin
    ctr_next = CTR_W'(sat_update(4'(ctr), taken, CTR_W));
  end

endmodule

// File: rtl/branch_predictor_table.sv
// branch_predictor_table: 2**IDX_W-entry table of CTR_W-bit saturating
// counters with a global history register.
//
// After reset the table is walked once, writing weakly-taken into every
// entry (2**IDX_W cycles); 'ready' then rises and stays high. Resolved
// branches are captured into a one-entry pending stage and written to the
// table on the following edge; a lookup that hits the pending index sees the
// pending (post-update) value, so back-to-back updates chain correctly.
//
// Optional feature: define BRANCH_PREDICTOR_GSHARE_EN to XOR the
// zero-extended ghr into the table index (lookup and update alike).
// Without it the index is the PC bits only; ghr is still tracked.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   lookup_valid/_pc   : decode-stage branch to predict
//   offset             : sign-extended branch immediate
//   prediction         : 1 = predict taken
//   target_addr        : lookup_pc + offset (always driven)
//   update_valid/_pc/_taken : resolved branch from the memory stage
//   ready              : initialisation complete
//   ghr                : global history (debug)
module branch_predictor_table
  import sail_bp_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 4,
  parameter int PC_LSB = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc,
  input  logic [31:0]       offset,
  output logic              prediction,
  output logic [31:0]       target_addr,
  input  logic              update_valid,
  input  logic [31:0]       update_pc,
  input  logic              update_taken,
  output logic              ready,
  output logic [HIST_W-1:0] ghr
);

  localparam int               DEPTH  = 1 << IDX_W;
  localparam logic [CTR_W-1:0] WEAK_T = CTR_W'(weak_t(CTR_W));

  logic [0:0]        state;
  logic [IDX_W-1:0]  init_ptr;
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_next;

  // pending update stage
  logic              pend_vld;
  logic [IDX_W-1:0]  pend_idx;
  logic              pend_taken;

  logic [CTR_W-1:0]  tbl [DEPTH];

  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  up_idx;
  logic [CTR_W-1:0]  ctr_wr;
  logic [CTR_W-1:0]  ctr_eff;
  logic              accept;
  logic              unused_pc_bits;

  assign ready  = (state == STATE_READY);
  assign ghr    = ghr_q;
  assign accept = update_valid & ready;

  // Only the index field of update_pc matters.
  assign unused_pc_bits = ^update_pc;

  // ---------------------------------------------------------------------
  // Index hash
  // ---------------------------------------------------------------------
`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_W-1:0] hist_ext;
  assign hist_ext = IDX_W'(ghr_q);
  // Both indices use the ghr before any shift from this cycle's capture.
  assign lk_idx   = lookup_pc[PC_LSB +: IDX_W] ^ hist_ext;
  assign up_idx   = update_pc[PC_LSB +: IDX_W] ^ hist_ext;
`else
  assign lk_idx   = lookup_pc[PC_LSB +: IDX_W];
  assign up_idx   = update_pc[PC_LSB +: IDX_W];
`endif

  // ---------------------------------------------------------------------
  // History shift value
  // ---------------------------------------------------------------------
  if (HIST_W == 1) begin : g_hist1
    assign ghr_next = update_taken;
  end else begin : g_histn
    assign ghr_next = {ghr_q[HIST_W-2:0], update_taken};
  end

  // ---------------------------------------------------------------------
  // Saturating update of the pending entry. The table is read at write
  // time, so a previous update to the same index has already landed.
  // ---------------------------------------------------------------------
  bp_sat_counter_update #(.CTR_W(CTR_W)) u_sat (
    .ctr      (tbl[pend_idx]),
    .taken    (pend_taken),
    .ctr_next (ctr_wr)
  );

  // ---------------------------------------------------------------------
  // Lookup with forwarding from the pending stage
  // ---------------------------------------------------------------------
  always_comb begin
    ctr_eff = tbl[lk_idx];
    if (pend_vld && (pend_idx == lk_idx)) ctr_eff = ctr_wr;
  end

  assign prediction  = ready & lookup_valid & ctr_eff[CTR_W-1];
  assign target_addr = lookup_pc + offset;

  // ---------------------------------------------------------------------
  // Control: init FSM, pending stage, history
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STATE_INIT;
      init_ptr   <= '0;
      ghr_q      <= '0;
      pend_vld   <= 1'b0;
      pend_idx   <= '0;
      pend_taken <= 1'b0;
    end else begin
      if (state == STATE_INIT) begin
        init_ptr <= init_ptr + IDX_W'(1);
        if (&init_ptr) state <= STATE_READY;
      end
      pend_vld <= accept;
      if (accept) begin
        pend_idx   <= up_idx;
        pend_taken <= update_taken;
        ghr_q      <= ghr_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Table storage (no reset; contents are established by the init walk).
  // Pending is never valid during INIT, so the two writers never collide.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == STATE_INIT)  tbl[init_ptr] <= WEAK_T;
    else if (pend_vld)        tbl[pend_idx] <= ctr_wr;
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
module tb_branch_predictor_table;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic [31:0] offset = '0;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic        prediction;
  logic [31:0] target_addr;
  logic        ready;
  logic [3:0]  ghr;

  always #5 clk = ~clk;

  branch_predictor_table dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .offset       (offset),
    .prediction   (prediction),
    .target_addr  (target_addr),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .ready        (ready),
    .ghr          (ghr)
  );

  typedef struct {
    string       name;
    logic        pred;
    logic [31:0] tgt;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // reference model: architectural table state (updates visible from the
  // cycle after capture), history, and the update captured this cycle
  int         mtbl[16];
  logic [3:0] mghr;
  bit         mready;
  bit         pu_v;
  logic [3:0] pu_idx;
  bit         pu_t;

  function automatic logic [3:0] midx(input logic [31:0] pc);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return pc[3:0] ^ mghr;
`else
    return pc[3:0];
`endif
  endfunction

  task automatic model_init();
    for (int i = 0; i < 16; i++) mtbl[i] = 2;
    mghr   = 4'd0;
    mready = 1'b0;
    pu_v   = 1'b0;
  endtask

  // Drives one cycle of stimulus at the falling edge and pushes the
  // expected lookup result for this cycle.
  task automatic drive_cycle(input string nm, input bit lv, input logic [31:0] lpc,
                             input logic [31:0] off, input bit uv,
                             input logic [31:0] upc, input bit ut);
    exp_t e;
    int   v;
    @(negedge clk);
    if (pu_v) begin
      v = mtbl[pu_idx];
      mtbl[pu_idx] = pu_t ? ((v < 3) ? v + 1 : 3) : ((v > 0) ? v - 1 : 0);
      mghr = {mghr[2:0], pu_t};
      pu_v = 1'b0;
    end
    lookup_valid = lv;  lookup_pc = lpc;  offset = off;
    update_valid = uv;  update_pc = upc;  update_taken = ut;
    e.name = nm;
    e.pred = mready && lv && (mtbl[midx(lpc)] >= 2);
    e.tgt  = lpc + off;
    sbq.push_back(e);
    if (uv && mready) begin
      pu_v   = 1'b1;
      pu_idx = midx(upc);
      pu_t   = ut;
    end
  endtask

  task automatic test_reset();
    int cyc;
    model_init();
    lookup_valid = 1'b1; lookup_pc = 32'h0;
    update_valid = 1'b1; update_pc = 32'h5; update_taken = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    tests++; if (ready !== 1'b0)      begin fails++; $display("FAIL rst_ready got %b want 0", ready); end
    tests++; if (prediction !== 1'b0) begin fails++; $display("FAIL rst_pred got %b want 0", prediction); end
    tests++; if (ghr !== 4'd0)        begin fails++; $display("FAIL rst_ghr got %h want 0", ghr); end
    @(negedge clk); rst_n = 1'b1;
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin cyc = c; break; end
      tests++;
      if (prediction !== 1'b0) begin fails++; $display("FAIL init_pred c=%0d got %b want 0", c, prediction); end
    end
    update_valid = 1'b0;
    tests++; if (cyc != 16) begin fails++; $display("FAIL init_cycles got %0d want 16", cyc); end
    mready = 1'b1;
    tests++; if (prediction !== 1'b1) begin fails++; $display("FAIL init_pred_after got %b want 1", prediction); end
    tests++; if (ghr !== 4'd0)        begin fails++; $display("FAIL init_ghr_dropped got %h want 0", ghr); end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      if (i < 4)       drive_cycle("sat_up",   1, 32'h5, 32'h8, 1, 32'h5, 1);
      else if (i == 4) drive_cycle("sat_top",  1, 32'h5, 32'h8, 0, 32'h0, 0);
      else if (i < 9)  drive_cycle("sat_down", 1, 32'h5, 32'h8, 1, 32'h5, 0);
      else             drive_cycle("sat_bot",  1, 32'h5, 32'h8, 0, 32'h0, 0);
      #2;
      if (sbq.size() == 0) begin tests++; fails++; $display("FAIL sat_sb_empty"); end
      else begin
        e = sbq.pop_front();
        tests++; if (prediction !== e.pred) begin fails++; $display("FAIL %s pred got %b want %b", e.name, prediction, e.pred); end
        tests++; if (target_addr !== e.tgt) begin fails++; $display("FAIL %s target got %h want %h", e.name, target_addr, e.tgt); end
        tests++; if (ghr !== mghr)          begin fails++; $display("FAIL %s ghr got %h want %h", e.name, ghr, mghr); end
      end
    end
  endtask

  task automatic test_forwarding();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive_cycle("fwd_n1",   0, 32'h3, 32'h0, 1, 32'h3, 0);
        1: drive_cycle("fwd_n2",   1, 32'h3, 32'h0, 1, 32'h3, 0);
        2: drive_cycle("fwd_look", 1, 32'h3, 32'h0, 0, 32'h0, 0);
        default: drive_cycle("fwd_after", 1, 32'h3, 32'h0, 0, 32'h0, 0);
      endcase
      #2;
      if (sbq.size() == 0) begin tests++; fails++; $display("FAIL fwd_sb_empty"); end
      else begin
        e = sbq.pop_front();
        tests++; if (prediction !== e.pred) begin fails++; $display("FAIL %s pred got %b want %b", e.name, prediction, e.pred); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 80; i++) begin
      drive_cycle("b2b", 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 4'($urandom_range(0, 15))},
                  $urandom, 1'($urandom_range(0, 3) != 0), {$urandom, 4'($urandom_range(0, 7))},
                  1'($urandom_range(0, 1)));
      #2;
      if (sbq.size() == 0) begin tests++; fails++; $display("FAIL b2b_sb_empty"); end
      else begin
        e = sbq.pop_front();
        tests++; if (prediction !== e.pred) begin fails++; $display("FAIL %s[%0d] pred got %b want %b", e.name, i, prediction, e.pred); end
        tests++; if (target_addr !== e.tgt) begin fails++; $display("FAIL %s[%0d] target got %h want %h", e.name, i, target_addr, e.tgt); end
        tests++; if (ghr !== mghr)          begin fails++; $display("FAIL %s[%0d] ghr got %h want %h", e.name, i, ghr, mghr); end
      end
    end
  endtask

  task automatic test_mid_init_and_target();
    exp_t e;
    int   cyc;
    @(negedge clk); rst_n = 1'b0; update_valid = 1'b0; model_init();
    #2;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_rst1_ready got %b want 0", ready); end
    tests++; if (ghr !== 4'd0)   begin fails++; $display("FAIL mid_rst1_ghr got %h want 0", ghr); end
    @(negedge clk); rst_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #2;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_rst2_ready got %b want 0", ready); end
    @(negedge clk); rst_n = 1'b1;
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      drive_cycle("init_tgt", 0, 32'hFFFF_FFF0, 32'h20, 1, 32'h5, 1);
      #2;
      if (sbq.size() == 0) begin tests++; fails++; $display("FAIL init_sb_empty"); end
      else begin
        e = sbq.pop_front();
        tests++; if (prediction !== e.pred) begin fails++; $display("FAIL %s pred got %b want %b", e.name, prediction, e.pred); end
        tests++; if (target_addr !== 32'h0000_0010) begin fails++; $display("FAIL %s target got %h want 00000010", e.name, target_addr); end
      end
      if (ready === 1'b1) begin cyc = c; update_valid = 1'b0; break; end
    end
    tests++; if (cyc != 16)    begin fails++; $display("FAIL mid_init_cycles got %0d want 16", cyc); end
    tests++; if (ghr !== 4'd0) begin fails++; $display("FAIL mid_init_ghr got %h want 0", ghr); end
    mready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive_cycle("tgt_wrap", 1, 32'hFFFF_FFF0, 32'h0000_0020, 0, 32'h0, 0);
        1: drive_cycle("tgt_neg",  1, 32'h0000_1000, 32'hFFFF_FFFC, 0, 32'h0, 0);
        default: drive_cycle("tgt_big", 1, 32'h8000_0000, 32'h8000_0004, 0, 32'h0, 0);
      endcase
      #2;
      if (sbq.size() == 0) begin tests++; fails++; $display("FAIL tgt_sb_empty"); end
      else begin
        e = sbq.pop_front();
        tests++; if (prediction !== e.pred) begin fails++; $display("FAIL %s pred got %b want %b", e.name, prediction, e.pred); end
        tests++; if (target_addr !== e.tgt) begin fails++; $display("FAIL %s target got %h want %h", e.name, target_addr, e.tgt); end
      end
    end
  endtask

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  task automatic test_gshare();
    exp_t e;
    // history 0->1->2->5->A, indices 0,1,2,5; then pc 5 ^ A = F
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive_cycle("gs_u0", 0, 32'h0, 32'h0, 1, 32'h0, 1);
        1: drive_cycle("gs_u1", 0, 32'h0, 32'h0, 1, 32'h0, 0);
        2: drive_cycle("gs_u2", 0, 32'h0, 32'h0, 1, 32'h0, 1);
        3: drive_cycle("gs_u3", 0, 32'h0, 32'h0, 1, 32'h0, 0);
        default: drive_cycle("gs_look", 1, 32'h5, 32'h0, 0, 32'h0, 0);
      endcase
      #2;
      if (sbq.size() == 0) begin tests++; fails++; $display("FAIL gs_sb_empty"); end
      else begin
        e = sbq.pop_front();
        tests++; if (prediction !== e.pred) begin fails++; $display("FAIL %s pred got %b want %b", e.name, prediction, e.pred); end
      end
    end
    tests++; if (ghr !== 4'b1010)    begin fails++; $display("FAIL gs_ghr got %b want 1010", ghr); end
    tests++; if (prediction !== 1'b1) begin fails++; $display("FAIL gs_entry_f got %b want 1", prediction); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_saturation();
    test_forwarding();
    test_back_to_back();
    test_mid_init_and_target();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    test_gshare();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
